// File: rtl/serial_rx_deframer.sv
// Serial link receiver: detects a start bit on S_Data, shifts in one
// DATA_WIDTH-bit payload LSB first, and offers it through a valid/ready
// output register. A frame that completes while the output register is
// still occupied and not being consumed is dropped and flagged.
module serial_rx_deframer #(
   parameter int unsigned DATA_WIDTH = 55,
   parameter int unsigned CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  S_Data,
   output logic [DATA_WIDTH-1:0] RX_Data,
   output logic                  RX_Data_Valid,
   input  logic                  RX_Data_Ready,
   output logic                  RX_Busy,
   output logic                  RX_Overrun
);

   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_DATA
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic                    overrun_q, overrun_d;
   logic                    complete;
   logic [DATA_WIDTH-1:0]   frame;

   // Next-state, shift path and output-register handshake
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      overrun_d = 1'b0;
      complete  = 1'b0;
      // Right-shift in at the MSB: after DATA_WIDTH shifts the first
      // received bit sits in bit 0. On the last bit this is the full payload.
      frame     = {S_Data, shift_q[DATA_WIDTH-1:1]};

      case (state_q)
         ST_IDLE: begin
            if (S_Data) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_DATA: begin
            shift_d = frame;
            if (cnt_q == LAST_BIT) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
               cnt_d    = '0;
               busy_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A completing frame may replace a payload that is consumed on the
      // same edge; otherwise it is discarded so RX_Data stays stable.
      if (complete) begin
         if (!valid_q || RX_Data_Ready) begin
            data_d  = frame;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && RX_Data_Ready) begin
         valid_d = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign RX_Data       = data_q;
   assign RX_Data_Valid = valid_q;
   assign RX_Busy       = busy_q;
   assign RX_Overrun    = overrun_q;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed bench for serial_rx_deframer: table of single frames plus
// hand-written back-to-back, overrun, mid-frame reset and loopback sequences.
module tb_serial_rx_deframer;

   localparam int unsigned DW = 55;

   logic          clk = 1'b0;
   logic          rst;
   logic          S_Data;
   logic [DW-1:0] RX_Data;
   logic          RX_Data_Valid;
   logic          RX_Data_Ready;
   logic          RX_Busy;
   logic          RX_Overrun;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Per-cycle bookkeeping updated by cyc()
   int unsigned vcount = 0;
   int unsigned ocount = 0;
   bit          lb_mode = 1'b0;
   int unsigned stall = 0;
   int unsigned n_acc = 0;
   logic [DW-1:0] exp_q[$];

   typedef struct {
      logic [DW-1:0] payload;
      int unsigned   hold;
      logic [DW-1:0] exp_data;
   } vec_t;

   serial_rx_deframer #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .S_Data        (S_Data),
      .RX_Data       (RX_Data),
      .RX_Data_Valid (RX_Data_Valid),
      .RX_Data_Ready (RX_Data_Ready),
      .RX_Busy       (RX_Busy),
      .RX_Overrun    (RX_Overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, then advance to 1 time unit after the edge
   task automatic cyc(input logic sd, input logic rdy);
      logic r;
      S_Data = sd;
      r = rdy;
      if (lb_mode) begin
         if (stall >= 6) r = 1'b1;
         else r = ($urandom_range(0, 2) != 0);
         if (RX_Data_Valid) begin
            if (r) stall = 0;
            else stall++;
         end
         if (RX_Data_Valid && r) begin
            if (exp_q.size() == 0) chk("lb_extra", 64'd1, 64'd0);
            else chk("lb_data", RX_Data, exp_q.pop_front());
            n_acc++;
         end
         chk("lb_overrun", RX_Overrun, 0);
      end
      RX_Data_Ready = r;
      if (RX_Data_Valid === 1'b1) vcount++;
      if (RX_Overrun === 1'b1) ocount++;
      @(posedge clk);
      #1;
   endtask

   // Start bit then DATA_WIDTH data bits; returns in the cycle after the last bit
   task automatic send_frame(input logic [DW-1:0] p, input logic rdy);
      cyc(1'b1, rdy);
      for (int i = 0; i < int'(DW); i++) begin
         chk("busy_in_frame", RX_Busy, 1);
         chk("overrun_in_frame", RX_Overrun, 0);
         cyc(p[i], rdy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[5];
      logic [63:0] rnd;
      logic [DW-1:0] w;

      vecs[0] = '{payload: 55'h2A_5A5A_5A5A_5A5A, hold: 0, exp_data: 55'h2A_5A5A_5A5A_5A5A};
      vecs[1] = '{payload: 55'h0,                 hold: 0, exp_data: 55'h0};
      vecs[2] = '{payload: 55'h7F_FFFF_FFFF_FFFF, hold: 2, exp_data: 55'h7F_FFFF_FFFF_FFFF};
      vecs[3] = '{payload: 55'h40_0000_0000_0000, hold: 0, exp_data: 55'h40_0000_0000_0000};
      vecs[4] = '{payload: 55'h1,                 hold: 5, exp_data: 55'h1};

      rst = 1'b1;
      S_Data = 1'b0;
      RX_Data_Ready = 1'b0;

      // Reset then idle
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      chk("rst_valid", RX_Data_Valid, 0);
      chk("rst_busy", RX_Busy, 0);
      chk("rst_data", RX_Data, 0);
      chk("rst_overrun", RX_Overrun, 0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b0);
         chk("idle_valid", RX_Data_Valid, 0);
         chk("idle_busy", RX_Busy, 0);
         chk("idle_data", RX_Data, 0);
      end

      // Table of single frames
      foreach (vecs[k]) begin
         vcount = 0;
         send_frame(vecs[k].payload, 1'b1);
         chk("frame_valid", RX_Data_Valid, 1);
         chk("frame_data", RX_Data, vecs[k].exp_data);
         chk("frame_busy_done", RX_Busy, 0);
         chk("frame_overrun", RX_Overrun, 0);
         for (int h = 0; h < int'(vecs[k].hold); h++) begin
            cyc(1'b0, 1'b0);
            chk("hold_valid", RX_Data_Valid, 1);
            chk("hold_data", RX_Data, vecs[k].exp_data);
         end
         cyc(1'b0, 1'b1);
         chk("consumed_valid", RX_Data_Valid, 0);
         chk("frame_valid_cycles", vcount, vecs[k].hold + 1);
      end

      // Back-to-back frames, consumer always ready
      vcount = 0;
      ocount = 0;
      send_frame(55'h0000_0000_0000_01, 1'b1);
      chk("b2b_valid_a", RX_Data_Valid, 1);
      chk("b2b_data_a", RX_Data, 55'h1);
      send_frame(55'h40_0000_0000_0000, 1'b1);
      chk("b2b_valid_b", RX_Data_Valid, 1);
      chk("b2b_data_b", RX_Data, 55'h40_0000_0000_0000);
      cyc(1'b0, 1'b1);
      chk("b2b_drained", RX_Data_Valid, 0);
      chk("b2b_valid_cycles", vcount, 2);
      chk("b2b_overruns", ocount, 0);

      // Overrun: second frame completes with output full and not ready
      vcount = 0;
      ocount = 0;
      send_frame(55'h1, 1'b0);
      chk("ovr_valid_1", RX_Data_Valid, 1);
      chk("ovr_data_1", RX_Data, 55'h1);
      chk("ovr_pulse_none", RX_Overrun, 0);
      send_frame(55'h2, 1'b0);
      chk("ovr_valid_2", RX_Data_Valid, 1);
      chk("ovr_data_kept", RX_Data, 55'h1);
      chk("ovr_pulse", RX_Overrun, 1);
      cyc(1'b0, 1'b0);
      chk("ovr_pulse_end", RX_Overrun, 0);
      chk("ovr_data_still", RX_Data, 55'h1);
      chk("ovr_valid_still", RX_Data_Valid, 1);
      cyc(1'b0, 1'b1);
      chk("ovr_drained", RX_Data_Valid, 0);
      chk("ovr_count", ocount, 1);

      // Reset in cycle 30 of a frame, then a full frame
      vcount = 0;
      cyc(1'b1, 1'b1);
      for (int i = 1; i < 30; i++) cyc(1'b1, 1'b1);
      rst = 1'b1;
      cyc(1'b1, 1'b1);
      rst = 1'b0;
      chk("midrst_busy", RX_Busy, 0);
      chk("midrst_valid", RX_Data_Valid, 0);
      chk("midrst_data", RX_Data, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1);
         chk("midrst_idle_busy", RX_Busy, 0);
      end
      chk("midrst_no_output", vcount, 0);
      send_frame(55'h7F_FFFF_FFFF_FFFF, 1'b1);
      chk("midrst_valid_after", RX_Data_Valid, 1);
      chk("midrst_data_after", RX_Data, 55'h7F_FFFF_FFFF_FFFF);
      cyc(1'b0, 1'b1);
      chk("midrst_drained", RX_Data_Valid, 0);

      // Loopback: random words, random bounded consumer stalls
      lb_mode = 1'b1;
      stall = 0;
      n_acc = 0;
      for (int n = 0; n < 20; n++) begin
         rnd = {$urandom, $urandom};
         w = rnd[DW-1:0];
         exp_q.push_back(w);
         send_frame(w, 1'b0);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) cyc(1'b0, 1'b0);
      end
      for (int t = 0; t < 100 && n_acc < 20; t++) cyc(1'b0, 1'b0);
      lb_mode = 1'b0;
      chk("lb_accepted", n_acc, 20);
      chk("lb_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
